// File: rtl/audio_mixer_if.sv
// Control, ROM and sound bundle of the sample-playback mixer.
// The host/ROM side uses master; the mixer itself uses slave.
interface audio_mixer_if #(
   parameter int NUM_CH   = 4,
   parameter int ADDR_W   = 20,
   parameter int SAMPLE_W = 6,
   parameter int OUT_W    = 32
);
   logic [NUM_CH-1:0]          trigger;
   logic [NUM_CH-1:0]          stop;
   logic [NUM_CH-1:0]          loop_en;
   logic [NUM_CH*ADDR_W-1:0]   ch_len;
   logic                       mute;
   logic [NUM_CH*ADDR_W-1:0]   rom_addr;
   logic [NUM_CH*SAMPLE_W-1:0] rom_data;
   logic signed [OUT_W-1:0]    sound;
   logic                       sound_valid;
   logic [NUM_CH-1:0]          active;
   logic [NUM_CH-1:0]          done;

   modport master (
      output trigger, stop, loop_en, ch_len, mute, rom_data,
      input  rom_addr, sound, sound_valid, active, done
   );

   modport slave (
      input  trigger, stop, loop_en, ch_len, mute, rom_data,
      output rom_addr, sound, sound_valid, active, done
   );
endinterface

// File: rtl/audio_mixer.sv
// Multi-channel sample player: each channel steps through its ROM at the sample tick,
// and the playing channels are summed into a left-justified signed sound word.
module audio_mixer #(
   parameter int NUM_CH   = 4,
   parameter int ADDR_W   = 20,
   parameter int SAMPLE_W = 6,
   parameter int OUT_W    = 32,
   parameter int CLK_DIV  = 1134
) (
   input logic          CLOCK_50,
   input logic          reset,
   audio_mixer_if.slave bus
);
   localparam int S     = SAMPLE_W + $clog2(NUM_CH);
   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [1:0] {IDLE, ARM, PLAY} state_t;

   state_t                     state    [NUM_CH];
   state_t                     state_nx [NUM_CH];
   logic [ADDR_W-1:0]          addr     [NUM_CH];
   logic [ADDR_W-1:0]          addr_nx  [NUM_CH];
   logic [ADDR_W-1:0]          len      [NUM_CH];
   logic signed [SAMPLE_W-1:0] samp     [NUM_CH];
   logic [NUM_CH-1:0]          start;
   logic [NUM_CH-1:0]          done_nx;
   logic [NUM_CH-1:0]          done_q;
   logic [NUM_CH-1:0]          active;
   logic [CNT_W-1:0]           cnt;
   logic                       tick;
   logic signed [S-1:0]        sum_p0;
   logic signed [OUT_W-1:0]    sound_p1;
   logic                       vld_p1;

   function automatic logic signed [S-1:0] sext(input logic signed [SAMPLE_W-1:0] x);
      return S'(x);
   endfunction

   function automatic logic signed [OUT_W-1:0] justify(input logic signed [S-1:0] x);
      logic signed [OUT_W-1:0] w;
      w = OUT_W'(x);
      return w << (OUT_W - S);
   endfunction

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign len[g]   = bus.ch_len[g*ADDR_W +: ADDR_W];
      assign samp[g]  = bus.rom_data[g*SAMPLE_W +: SAMPLE_W];
      assign start[g] = bus.trigger[g] && (len[g] != '0);
      assign bus.rom_addr[g*ADDR_W +: ADDR_W] = addr[g];
   end

   assign tick = (cnt == CNT_W'(CLK_DIV - 1));

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset)     cnt <= '0;
      else if (tick) cnt <= '0;
      else           cnt <= cnt + 1'b1;
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            state[i] <= IDLE;
            addr[i]  <= '0;
         end
         done_q <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            state[i] <= state_nx[i];
            addr[i]  <= addr_nx[i];
         end
         done_q <= done_nx;
      end
   end

   // stop outranks trigger; a zero length (or a shrunk one) counts as end of sample
   always_comb begin
      done_nx = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         state_nx[i] = state[i];
         addr_nx[i]  = addr[i];
         if (bus.stop[i]) begin
            state_nx[i] = IDLE;
            addr_nx[i]  = '0;
         end else if (start[i]) begin
            state_nx[i] = ARM;
            addr_nx[i]  = '0;
         end else begin
            case (state[i])
               ARM:  state_nx[i] = PLAY;
               PLAY: begin
                  if (tick) begin
                     if ((len[i] == '0) || (addr[i] >= len[i] - 1'b1)) begin
                        addr_nx[i] = '0;
                        if (!bus.loop_en[i]) begin
                           state_nx[i] = IDLE;
                           done_nx[i]  = 1'b1;
                        end
                     end else begin
                        addr_nx[i] = addr[i] + 1'b1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      sum_p0 = '0;
      active = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         active[i] = (state[i] != IDLE);
         if (tick && (state[i] == PLAY) && !bus.stop[i] && !start[i])
            sum_p0 = sum_p0 + sext(samp[i]);
      end
   end

   // ---- p0 -> p1: mix register, loaded once per tick ----
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         sound_p1 <= '0;
         vld_p1   <= 1'b0;
      end else begin
         vld_p1 <= tick;
         if (tick) sound_p1 <= bus.mute ? '0 : justify(sum_p0);
      end
   end

   assign bus.sound       = sound_p1;
   assign bus.sound_valid = vld_p1;
   assign bus.active      = active;
   assign bus.done        = done_q;
endmodule
